// File: rtl/max_argmax_stream.sv
// max_argmax_stream
//    Streaming max-reduction engine. Each beat carries N lanes of DATA_W-bit
//    values. A pipelined comparator tree (one register stage per level)
//    reduces a beat to a single {value, lane} winner. An accumulator then folds
//    successive beats into a running maximum until in_last. It reports the
//    window maximum, its lane, its beat position and the window length.
//
// Ports
//    clk        rising-edge clock
//    reset      asynchronous, active-low reset
//    in_valid   beat present on in_data / in_last
//    in_ready   beat accepted when in_valid & in_ready
//    in_data    N lanes, lane i = in_data[i*DATA_W +: DATA_W]
//    in_last    final beat of the current window
//    out_valid  window result valid, held until out_ready
//    out_ready  downstream accepts the result
//    out_max    maximum over every lane and beat of the window
//    out_idx    lane of the winning element
//    out_beat   0-based beat of the winning element (saturating)
//    out_count  number of beats in the window (saturating)

module max_argmax_stream #(
   parameter int N      = 8,
   parameter int DATA_W = 8,
   parameter int SIGNED = 0,
   parameter int BEAT_W = 8,
   localparam int L     = $clog2(N),
   localparam int IDX_W = (L > 1) ? L : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DATA_W-1:0]   in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_max,
   output logic [IDX_W-1:0]      out_idx,
   output logic [BEAT_W-1:0]     out_beat,
   output logic [BEAT_W-1:0]     out_count
);

   // Strict "a beats b" comparison. Ties return 0, so the left operand
   // (lower lane, or earlier beat) always survives a tie.
   function automatic logic greater(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
      if (SIGNED != 0) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   logic en;
   logic accept;

   // The whole pipeline freezes only while a finished result is waiting on
   // downstream. Every stage shares this single enable.
   assign en       = ~(out_valid & ~out_ready);
   assign in_ready = en;
   assign accept   = in_valid & en;

   // The tree is stored heap-style: node i has children 2i (left, lower
   // lanes) and 2i+1 (right). Nodes 1..N-1 are registers, and node 1 is the
   // root. Heap positions N..2N-1 are the input lanes themselves.
   logic [DATA_W-1:0] node_val [1:N-1];
   logic [IDX_W-1:0]  node_idx [1:N-1];
   logic [DATA_W-1:0] cand_val [2:2*N-1];
   logic [IDX_W-1:0]  cand_idx [2:2*N-1];
   logic [DATA_W-1:0] nxt_val  [1:N-1];
   logic [IDX_W-1:0]  nxt_idx  [1:N-1];

   // Per-level valid and last tags. Bit 0 belongs to the level fed directly
   // by the input lanes, and bit L-1 belongs to the root.
   logic [L-1:0] vld_pipe;
   logic [L-1:0] last_pipe;

   // Presents registered inner nodes and raw input lanes through one uniform
   // child view, so every node is computed the same way.
   always_comb begin
      for (int j = 2; j < N; j++) begin
         cand_val[j] = node_val[j];
         cand_idx[j] = node_idx[j];
      end
      for (int j = N; j < 2 * N; j++) begin
         cand_val[j] = in_data[(j - N) * DATA_W +: DATA_W];
         cand_idx[j] = IDX_W'(j - N);
      end
   end

   // Each node takes the right child only if it is strictly larger. The lowest
   // lane holding the maximum therefore reaches the root.
   always_comb begin
      for (int i = 1; i < N; i++) begin
         nxt_val[i] = cand_val[2 * i];
         nxt_idx[i] = cand_idx[2 * i];
         if (greater(cand_val[2 * i + 1], cand_val[2 * i])) begin
            nxt_val[i] = cand_val[2 * i + 1];
            nxt_idx[i] = cand_idx[2 * i + 1];
         end
      end
   end

   // All tree levels advance together. Each level reads only the registers
   // of the level below, so one shared register update moves every beat up by
   // one level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
         for (int i = 1; i < N; i++) begin
            node_val[i] <= '0;
            node_idx[i] <= '0;
         end
      end else if (en) begin
         vld_pipe[0]  <= accept;
         last_pipe[0] <= in_last;
         for (int k = 1; k < L; k++) begin
            vld_pipe[k]  <= vld_pipe[k - 1];
            last_pipe[k] <= last_pipe[k - 1];
         end
         for (int i = 1; i < N; i++) begin
            node_val[i] <= nxt_val[i];
            node_idx[i] <= nxt_idx[i];
         end
      end
   end

   logic              root_vld;
   logic              root_last;
   logic              acc_full;
   logic [DATA_W-1:0] acc_val;
   logic [IDX_W-1:0]  acc_idx;
   logic [BEAT_W-1:0] acc_beat;
   logic [BEAT_W-1:0] cnt;
   logic [DATA_W-1:0] m_val;
   logic [IDX_W-1:0]  m_idx;
   logic [BEAT_W-1:0] m_beat;
   logic [BEAT_W-1:0] m_cnt;

   assign root_vld  = vld_pipe[L - 1];
   assign root_last = last_pipe[L - 1];

   // Merges the root winner into the running window state. The running count
   // equals the index of the incoming beat, and it stops at all-ones.
   // Replacement is strict, so the earliest beat keeps a tied maximum.
   always_comb begin
      m_val  = node_val[1];
      m_idx  = node_idx[1];
      m_beat = '0;
      m_cnt  = BEAT_W'(1);
      if (acc_full) begin
         m_cnt = (cnt == '1) ? cnt : cnt + BEAT_W'(1);
         if (greater(node_val[1], acc_val)) begin
            m_beat = cnt;
         end else begin
            m_val  = acc_val;
            m_idx  = acc_idx;
            m_beat = acc_beat;
         end
      end
   end

   // A last beat publishes the merged result and empties the accumulator.
   // Any other beat just updates it. out_valid is recomputed whenever the
   // pipeline moves. That lets a new result replace one being taken in the
   // same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_full  <= 1'b0;
         acc_val   <= '0;
         acc_idx   <= '0;
         acc_beat  <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_max   <= '0;
         out_idx   <= '0;
         out_beat  <= '0;
         out_count <= '0;
      end else if (en) begin
         out_valid <= root_vld & root_last;
         if (root_vld) begin
            if (root_last) begin
               out_max   <= m_val;
               out_idx   <= m_idx;
               out_beat  <= m_beat;
               out_count <= m_cnt;
               acc_full  <= 1'b0;
            end else begin
               acc_val   <= m_val;
               acc_idx   <= m_idx;
               acc_beat  <= m_beat;
               cnt       <= m_cnt;
               acc_full  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_max_argmax_stream.sv
// tb_max_argmax_stream
//    Drives three copies of max_argmax_stream from one shared beat stream:
//    unsigned with an 8-bit beat count, signed with an 8-bit beat count, and
//    unsigned with a 2-bit beat count. Each accepted window pushes one
//    reference result per copy into a queue. A monitor compares every
//    presented result against the front of the matching queue.

module tb_max_argmax_stream;

   localparam int N  = 8;
   localparam int DW = 8;

   typedef struct packed {
      logic [7:0] mx;
      logic [2:0] idx;
      logic [7:0] beat;
      logic [7:0] cnt;
   } res_t;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_last;
   logic          out_ready;
   logic [N*DW-1:0] in_data;
   logic          rdyU, rdyS, rdyB, in_ready;
   logic          vU, vS, vB;
   logic [7:0]    maxU, maxS, maxB;
   logic [2:0]    idxU, idxS, idxB;
   logic [7:0]    beatU, beatS, cntU, cntS;
   logic [1:0]    beatB, cntB;

   int checks    = 0;
   int errors    = 0;
   int readyMode = 1;

   res_t          expQ [3][$];
   logic [N*DW-1:0] curBeats [$];
   res_t          act [3];
   logic          actValid [3];

   assign in_ready    = rdyU & rdyS & rdyB;
   assign act[0]      = {maxU, idxU, beatU, cntU};
   assign act[1]      = {maxS, idxS, beatS, cntS};
   assign act[2]      = {maxB, idxB, 6'b0, beatB, 6'b0, cntB};
   assign actValid[0] = vU;
   assign actValid[1] = vS;
   assign actValid[2] = vB;

   max_argmax_stream #(.N(N), .DATA_W(DW), .SIGNED(0), .BEAT_W(8)) dutU (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyU),
      .in_data(in_data), .in_last(in_last), .out_valid(vU), .out_ready(out_ready),
      .out_max(maxU), .out_idx(idxU), .out_beat(beatU), .out_count(cntU));

   max_argmax_stream #(.N(N), .DATA_W(DW), .SIGNED(1), .BEAT_W(8)) dutS (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyS),
      .in_data(in_data), .in_last(in_last), .out_valid(vS), .out_ready(out_ready),
      .out_max(maxS), .out_idx(idxS), .out_beat(beatS), .out_count(cntS));

   max_argmax_stream #(.N(N), .DATA_W(DW), .SIGNED(0), .BEAT_W(2)) dutB (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyB),
      .in_data(in_data), .in_last(in_last), .out_valid(vB), .out_ready(out_ready),
      .out_max(maxB), .out_idx(idxB), .out_beat(beatB), .out_count(cntB));

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream readiness: 0 = random, 1 = always ready, 2 = stalled.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Reference result for one complete window. The scan finds the maximum
   // over all elements, then picks the first (beat, lane) position holding it.
   // Variant 1 compares signed values, and variant 2 saturates beats at 3.
   function automatic res_t refModel(input int variant, input logic [N*DW-1:0] beats [$]);
      int best;
      int v;
      int satMax;
      bit found;
      logic [N*DW-1:0] bw;
      logic [DW-1:0] lane;
      res_t r;
      satMax = (variant == 2) ? 3 : 255;
      best   = -100000;
      foreach (beats[b]) begin
         bw = beats[b];
         for (int i = 0; i < N; i++) begin
            lane = bw[i*DW +: DW];
            v = (variant == 1) ? int'($signed(lane)) : int'(lane);
            if (v > best) best = v;
         end
      end
      r = '0;
      found = 1'b0;
      foreach (beats[b]) begin
         bw = beats[b];
         for (int i = 0; i < N; i++) begin
            lane = bw[i*DW +: DW];
            v = (variant == 1) ? int'($signed(lane)) : int'(lane);
            if (!found && v == best) begin
               found  = 1'b1;
               r.mx   = lane;
               r.idx  = 3'(i);
               r.beat = 8'((b > satMax) ? satMax : b);
            end
         end
      end
      r.cnt = 8'((beats.size() > satMax) ? satMax : beats.size());
      return r;
   endfunction

   function automatic logic [N*DW-1:0] packLanes(input logic [7:0] l [N]);
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = l[i];
      return r;
   endfunction

   // Small-range values make ties between lanes and beats common.
   function automatic logic [N*DW-1:0] randBeat(input bit tie, input int hi);
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++)
         r[i*DW +: DW] = tie ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, hi));
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Presents one beat, waits (bounded) for the handshake, and records the
   // accepted beat in the reference model.
   task automatic applyStimulus(input logic [N*DW-1:0] d, input logic l);
      int w;
      logic ok;
      w = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      ok = in_ready;
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL handshake timeout: in_ready 0 for %0d cycles, expected 1", w);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (ok) begin
         curBeats.push_back(d);
         if (l) begin
            for (int v = 0; v < 3; v++) expQ[v].push_back(refModel(v, curBeats));
            curBeats.delete();
         end
      end
   endtask

   task automatic sendWindow(input int len, input bit tie, input bit gaps);
      for (int b = 0; b < len; b++) begin
         if (gaps && $urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
         applyStimulus(randBeat(tie, 255), b == len - 1);
      end
   endtask

   // Waits until every issued window has been reported and taken.
   task automatic drainAll();
      int w;
      w = 0;
      readyMode = 1;
      while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      if ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain timeout: %0d results outstanding, expected 0",
                  expQ[0].size() + expQ[1].size() + expQ[2].size());
         for (int v = 0; v < 3; v++) expQ[v].delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: checks every presented result. The queue is popped
   // only when the result is actually taken, so held results are re-checked
   // each cycle.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            for (int v = 0; v < 3; v++) begin
               if (actValid[v]) begin
                  if (expQ[v].size() == 0) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL unexpected result dut%0d: got 0x%0h, expected none", v, act[v]);
                  end else begin
                     e = expQ[v][0];
                     checkOutput($sformatf("result dut%0d {max,idx,beat,count}", v), 32'(act[v]), 32'(e));
                     if (out_ready) void'(expQ[v].pop_front());
                  end
               end
            end
         end
      end
   end

   // Keeps a broken design from hanging the run.
   initial begin
      #500000;
      checks++;
      errors++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      logic [7:0] lanes [N];
      logic [N*DW-1:0] bv;
      int lat;

      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("reset out_valid", 32'(vU), 0);
      checkOutput("reset out_max", 32'(maxU), 0);
      checkOutput("reset out_idx", 32'(idxU), 0);
      checkOutput("reset out_beat", 32'(beatU), 0);
      checkOutput("reset out_count", 32'(cntU), 0);
      checkOutput("reset in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single-beat window, latency, and fixed expected values.
      $display("[TB] single-beat window");
      lanes = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd2, 8'd7, 8'd5};
      applyStimulus(packLanes(lanes), 1'b1);
      lat = 1;
      while (!vU && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("t1 latency", 32'(lat), 4);
      checkOutput("t1 out_max", 32'(maxU), 9);
      checkOutput("t1 out_idx", 32'(idxU), 1);
      checkOutput("t1 out_beat", 32'(beatU), 0);
      checkOutput("t1 out_count", 32'(cntU), 1);
      drainAll();

      // Equal maxima in beats 1 and 2: the earlier beat must win.
      $display("[TB] tie across beats");
      applyStimulus(randBeat(1'b0, 8'h3F), 1'b0);
      bv = randBeat(1'b0, 8'h3F);
      bv[6*DW +: DW] = 8'h40;
      applyStimulus(bv, 1'b0);
      bv = randBeat(1'b0, 8'h3F);
      bv[2*DW +: DW] = 8'h40;
      applyStimulus(bv, 1'b1);
      drainAll();

      // Signed versus unsigned ordering of the same bits.
      $display("[TB] signed compare");
      lanes = '{8'hFF, 8'h80, 8'h05, 8'hFD, 8'hF0, 8'h01, 8'h03, 8'h04};
      applyStimulus(packLanes(lanes), 1'b1);
      drainAll();

      // Downstream stall while two windows stream in.
      $display("[TB] downstream stall");
      readyMode = 2;
      fork
         begin
            sendWindow(2, 1'b0, 1'b0);
            sendWindow(1, 1'b1, 1'b0);
            sendWindow(3, 1'b0, 1'b0);
         end
         begin
            int w;
            w = 0;
            while (!vU && w < 100) begin
               @(negedge clk);
               w++;
            end
            repeat (5) @(negedge clk);
            checkOutput("stall in_ready", 32'(in_ready), 0);
            checkOutput("stall out_valid", 32'(vU), 1);
            readyMode = 1;
         end
      join
      drainAll();

      // Reset in the middle of a window discards the partial window.
      $display("[TB] reset mid-window");
      applyStimulus(randBeat(1'b0, 255), 1'b0);
      in_valid = 1'b1;
      in_data  = randBeat(1'b0, 255);
      in_last  = 1'b0;
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("mid-reset out_valid", 32'(vU), 0);
      checkOutput("mid-reset out_max", 32'(maxU), 0);
      checkOutput("mid-reset out_idx", 32'(idxU), 0);
      checkOutput("mid-reset out_count", 32'(cntU), 0);
      checkOutput("mid-reset in_ready", 32'(in_ready), 1);
      curBeats.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(randBeat(1'b0, 255), 1'b1);
      drainAll();

      // Six beats with a unique maximum in beat 5.
      $display("[TB] beat saturation");
      for (int b = 0; b < 6; b++) begin
         bv = randBeat(1'b0, 8'h70);
         if (b == 5) bv[4*DW +: DW] = 8'h7E;
         applyStimulus(bv, b == 5);
      end
      drainAll();

      // Long window that saturates the 8-bit count as well.
      for (int b = 0; b < 260; b++) begin
         bv = randBeat(1'b0, 8'hEF);
         if (b == 258) bv[3*DW +: DW] = 8'hFF;
         applyStimulus(bv, b == 259);
      end
      drainAll();

      // Random windows with random backpressure and input gaps.
      $display("[TB] random windows");
      readyMode = 0;
      for (int k = 0; k < 40; k++)
         sendWindow($urandom_range(1, 6), $urandom_range(0, 1) == 1, 1'b1);
      drainAll();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
